edge_pulser: RTL and testbench
==============================

Name: edge_pulser

Overview:
Multi-channel successor to the single-input rising-edge one-shot. Each channel synchronises an asynchronous level input (button/switch), debounces it, and emits a one-cycle pulse on a selectable edge. Rising-edge mode can optionally auto-repeat while the input is held. It sits between board inputs and game/control logic, for example snake direction keys.

Parameters:
CHANNELS, 4, number of independent input channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
DEBOUNCE, 16, consecutive cycles a new synced level must persist before acceptance (>=1)
REPEAT_DELAY, 0, cycles from an accepted rise to the first repeat pulse; 0 disables auto-repeat
REPEAT_RATE, 8, cycles between subsequent repeat pulses (>=1; ignored if REPEAT_DELAY=0)
RESET_LEVEL, 1, value loaded into synchroniser and debounced level on reset

Ports:
clk  in  1  rising-edge clock; the block uses one clock
reset  in  1  synchronous, active-high reset
trigger_in  in  CHANNELS  raw asynchronous level inputs, one bit per channel
edge_mode  in  2*CHANNELS  per-channel mode; ch i uses bits [2i+1:2i]; 00 rise, 01 fall, 10 both, 11 pulses disabled
pulse_out  out  CHANNELS  registered one-cycle pulse per channel
level_out  out  CHANNELS  registered debounced level per channel
any_pulse  out  1  OR of pulse_out (combinational from registers)

Behaviour:
- Reset (sampled at posedge with reset=1):
  - All synchroniser flops and level_out = RESET_LEVEL.
  - Debounce and repeat counters = 0; pulse_out = 0.
  - Reset wins over all other activity; an in-progress debounce or repeat is abandoned.
- Synchroniser: trigger_in passes through SYNC_STAGES flops; sync_q is the last stage.
- Debounce, per channel, each edge:
  - If sync_q == level_out: counter <= 0.
  - Else if counter == DEBOUNCE-1: level_out <= sync_q and counter <= 0 (accepted transition).
  - Else: counter <= counter+1.
  - Any single cycle where sync_q matches level_out restarts the count, so glitches shorter than DEBOUNCE cycles are rejected.
- Latency:
  - A new level first sampled at edge k is accepted at edge k+SYNC_STAGES+DEBOUNCE-1.
  - The pulse_out for that transition is high in the cycle following the same edge.
- Edge pulse: set at the edge of an accepted transition when edge_mode permits.
  - rise: 0->1. fall: 1->0. both: either. 11: never.
  - edge_mode is sampled at the acceptance edge only; a mode change between transitions has no other effect.
  - level_out tracks the input in every mode.
- Post-reset: if RESET_LEVEL differs from the settled input, the first accepted transition is a genuine edge and pulses per mode. For example, RESET_LEVEL=1, input low, fall mode gives one pulse.
- Auto-repeat (REPEAT_DELAY>0, rise mode only):
  - The repeat counter clears on the accepted rise and increments each cycle level_out=1.
  - Repeat pulses occur at REPEAT_DELAY, REPEAT_DELAY+REPEAT_RATE, REPEAT_DELAY+2*REPEAT_RATE, ... cycles after the rise pulse.
  - The counter stops and clears when level_out goes 0 or the mode leaves rise.
  - The counter saturates/wraps only within the repeat period; it never overflows into spurious pulses.
- pulse_out is never high on two consecutive cycles from the edge path. The repeat path guarantees at least REPEAT_RATE-1 low cycles between pulses (REPEAT_RATE=1 gives a continuous high).
- Channels are fully independent; simultaneous events on several channels each pulse in the same cycle.
- Counter widths: clog2 of DEBOUNCE, REPEAT_DELAY, REPEAT_RATE (minimum 1 bit).

Test Plan:
(Bench parameters: CHANNELS=2, SYNC_STAGES=2, DEBOUNCE=4, REPEAT_DELAY=10, REPEAT_RATE=3, RESET_LEVEL=1.)
- Reset, then hold trigger_in=2'b11 for 20 cycles in rise mode -> pulse_out stays 0, level_out=2'b11 throughout.
- ch0 rise mode, input 1->0 settles, then 0->1 first sampled at edge k -> exactly one pulse_out[0], high after edge k+5; level_out[0] rises at the same edge.
- ch0 rise mode, 3-cycle high glitch on a low input -> no pulse, level_out[0] stays 0. A 4-cycle high -> one pulse.
- ch1 mode 10 (both), input toggled with 12-cycle periods -> one pulse per accepted transition, both directions. Mode 11 with the same stimulus -> no pulses, level_out[1] still toggles.
- ch0 rise with repeat, held high for 25 cycles after acceptance -> pulses at acceptance+0, +10, +13, +16, +19, +22. Release -> no further pulses.
- Assert reset mid-debounce (counter=2) and mid-repeat -> next cycle all pulse_out=0, level_out=2'b11, counters 0. Input held low afterwards in fall mode -> one pulse 5 edges after reset deasserts.

Source files
------------

// File: rtl/edge_pulser.sv
// Multi-channel input conditioner: synchronise, debounce and emit one-cycle edge pulses,
// with optional auto-repeat while a channel is held high in rise mode.
module edge_pulser #(
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned DEBOUNCE     = 16,
    parameter int unsigned REPEAT_DELAY = 0,
    parameter int unsigned REPEAT_RATE  = 8,
    parameter bit          RESET_LEVEL  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CHANNELS-1:0]   trigger_in,
    input  logic [2*CHANNELS-1:0] edge_mode,
    output logic [CHANNELS-1:0]   pulse_out,
    output logic [CHANNELS-1:0]   level_out,
    output logic                  any_pulse
);

    localparam int unsigned DB_W    = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int unsigned DLY_W   = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;
    localparam int unsigned RATE_W  = (REPEAT_RATE > 1) ? $clog2(REPEAT_RATE) : 1;
    localparam int unsigned RPT_W   = (DLY_W > RATE_W) ? DLY_W : RATE_W;
    localparam int unsigned DB_M1   = (DEBOUNCE > 0) ? DEBOUNCE - 1 : 0;
    localparam int unsigned DLY_M1  = (REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0;
    localparam int unsigned RATE_M1 = (REPEAT_RATE > 0) ? REPEAT_RATE - 1 : 0;
    localparam bit          RPT_EN  = (REPEAT_DELAY > 0);

    localparam logic [1:0] MODE_RISE = 2'b00;
    localparam logic [1:0] MODE_FALL = 2'b01;
    localparam logic [1:0] MODE_BOTH = 2'b10;

    typedef enum logic [1:0] {
        RPT_IDLE  = 2'b00,
        RPT_DELAY = 2'b01,
        RPT_RATE  = 2'b10
    } rpt_state_e;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   sync_last;
        logic [1:0]             mode;
        logic                   level_q, level_d;
        logic [DB_W-1:0]        deb_q, deb_d;
        rpt_state_e             rpt_state_q, rpt_state_d;
        logic [RPT_W-1:0]       rpt_cnt_q, rpt_cnt_d;
        logic                   pulse_q, pulse_d;
        logic                   accept;

        assign sync_last = sync_q[SYNC_STAGES-1];
        assign mode      = edge_mode[2*i +: 2];

        // Synchroniser chain, oldest sample in the top bit.
        always_ff @(posedge clk) begin
            if (reset) begin
                sync_q <= {SYNC_STAGES{RESET_LEVEL}};
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], trigger_in[i]};
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                level_q     <= RESET_LEVEL;
                deb_q       <= '0;
                rpt_state_q <= RPT_IDLE;
                rpt_cnt_q   <= '0;
                pulse_q     <= 1'b0;
            end else begin
                level_q     <= level_d;
                deb_q       <= deb_d;
                rpt_state_q <= rpt_state_d;
                rpt_cnt_q   <= rpt_cnt_d;
                pulse_q     <= pulse_d;
            end
        end

        always_comb begin
            level_d     = level_q;
            deb_d       = deb_q;
            accept      = 1'b0;
            rpt_state_d = rpt_state_q;
            rpt_cnt_d   = rpt_cnt_q;
            pulse_d     = 1'b0;

            // Any cycle agreeing with the held level restarts the debounce window.
            if (sync_last == level_q) begin
                deb_d = '0;
            end else if (deb_q == DB_W'(DB_M1)) begin
                level_d = sync_last;
                deb_d   = '0;
                accept  = 1'b1;
            end else begin
                deb_d = deb_q + DB_W'(1);
            end

            if (accept) begin
                case (mode)
                    MODE_RISE: pulse_d = level_d;
                    MODE_FALL: pulse_d = ~level_d;
                    MODE_BOTH: pulse_d = 1'b1;
                    default:   pulse_d = 1'b0;
                endcase
            end

            // Repeat runs only while held high in rise mode; anything else cancels it.
            if (!RPT_EN || !level_d || (mode != MODE_RISE)) begin
                rpt_state_d = RPT_IDLE;
                rpt_cnt_d   = '0;
            end else if (accept) begin
                rpt_state_d = RPT_DELAY;
                rpt_cnt_d   = '0;
            end else begin
                case (rpt_state_q)
                    RPT_DELAY: begin
                        if (rpt_cnt_q == RPT_W'(DLY_M1)) begin
                            pulse_d     = 1'b1;
                            rpt_cnt_d   = '0;
                            rpt_state_d = RPT_RATE;
                        end else begin
                            rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
                        end
                    end
                    RPT_RATE: begin
                        if (rpt_cnt_q == RPT_W'(RATE_M1)) begin
                            pulse_d   = 1'b1;
                            rpt_cnt_d = '0;
                        end else begin
                            rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
                        end
                    end
                    default: begin
                        rpt_state_d = RPT_IDLE;
                        rpt_cnt_d   = '0;
                    end
                endcase
            end
        end

        assign pulse_out[i] = pulse_q;
        assign level_out[i] = level_q;
    end

    assign any_pulse = |pulse_out;

endmodule

// File: tb/tb_edge_pulser.sv
// Directed + randomized bench for edge_pulser, checked cycle-by-cycle against a window/arithmetic model.
module tb_edge_pulser;

    localparam int CH = 2;
    localparam int SS = 2;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RR = 3;

    logic          clk;
    logic          reset;
    logic [CH-1:0] trigger_in;
    logic [2*CH-1:0] edge_mode;
    logic [CH-1:0] pulse_out;
    logic [CH-1:0] level_out;
    logic          any_pulse;

    edge_pulser #(
        .CHANNELS    (CH),
        .SYNC_STAGES (SS),
        .DEBOUNCE    (DB),
        .REPEAT_DELAY(RD),
        .REPEAT_RATE (RR),
        .RESET_LEVEL (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .trigger_in(trigger_in),
        .edge_mode (edge_mode),
        .pulse_out (pulse_out),
        .level_out (level_out),
        .any_pulse (any_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: per-channel sample history (bit j = sample taken j edges ago).
    logic [15:0]   hist [CH];
    logic [CH-1:0] m_lvl;
    logic [CH-1:0] m_pulse;
    bit            rep_valid [CH];
    int            rep_n [CH];
    int            pc [CH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        for (int c = 0; c < CH; c++) begin
            if (reset) begin
                hist[c]      = 16'hFFFF;
                m_lvl[c]     = 1'b1;
                m_pulse[c]   = 1'b0;
                rep_valid[c] = 1'b0;
                rep_n[c]     = 0;
            end else begin
                logic [1:0] mode;
                bit all1, all0, acc, p;
                mode    = edge_mode[2*c +: 2];
                hist[c] = {hist[c][14:0], trigger_in[c]};
                all1 = 1'b1;
                all0 = 1'b1;
                // Accept when the last DB synchronised samples agree and differ from the level.
                for (int j = SS; j < SS + DB; j++) begin
                    if (hist[c][j]) all0 = 1'b0;
                    else            all1 = 1'b0;
                end
                acc = (all1 && !m_lvl[c]) || (all0 && m_lvl[c]);
                p   = 1'b0;
                if (acc) begin
                    m_lvl[c] = ~m_lvl[c];
                    p = (mode == 2'b10) || (mode == 2'b00 && m_lvl[c]) || (mode == 2'b01 && !m_lvl[c]);
                end
                if (acc && m_lvl[c] && mode == 2'b00 && RD > 0) begin
                    rep_valid[c] = 1'b1;
                    rep_n[c]     = 0;
                end else if (rep_valid[c]) begin
                    if (m_lvl[c] && mode == 2'b00) begin
                        rep_n[c]++;
                        if (rep_n[c] == RD || (rep_n[c] > RD && (rep_n[c] - RD) % RR == 0)) p = 1'b1;
                    end else begin
                        rep_valid[c] = 1'b0;
                    end
                end
                m_pulse[c] = p;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("pulse_out", 32'(pulse_out), 32'(m_pulse));
        chk("level_out", 32'(level_out), 32'(m_lvl));
        chk("any_pulse", 32'(any_pulse), 32'(|m_pulse));
        for (int c = 0; c < CH; c++) pc[c] += int'(pulse_out[c]);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clr_pc();
        for (int c = 0; c < CH; c++) pc[c] = 0;
    endtask

    initial begin
        int pos;
        int hold [CH];

        reset      = 1'b1;
        trigger_in = 2'b11;
        edge_mode  = 4'b0000;
        for (int c = 0; c < CH; c++) begin
            hist[c] = 16'hFFFF; rep_valid[c] = 1'b0; rep_n[c] = 0; pc[c] = 0; hold[c] = 0;
        end
        m_lvl = 2'b11;
        m_pulse = 2'b00;
        ticks(3);
        chk("reset_level", 32'(level_out), 32'h3);
        chk("reset_pulse", 32'(pulse_out), 32'h0);
        reset = 1'b0;

        // Held high from reset: no edges.
        clr_pc();
        ticks(20);
        chk("idle_pulses", 32'(pc[0] + pc[1]), 32'd0);
        chk("idle_level", 32'(level_out), 32'h3);

        // ch0 settles low (no pulse in rise mode), then a clean rise.
        trigger_in[0] = 1'b0;
        clr_pc();
        ticks(12);
        chk("fall_in_rise_mode", 32'(pc[0]), 32'd0);
        chk("fall_level", 32'(level_out[0]), 32'd0);
        trigger_in[0] = 1'b1;
        clr_pc();
        pos = -1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (pulse_out[0] && pos < 0) pos = i;
        end
        chk("rise_latency", 32'(pos), 32'd6);
        chk("rise_count", 32'(pc[0]), 32'd1);
        trigger_in[0] = 1'b0;
        ticks(12);

        // Short glitch rejected, DB-long high accepted.
        clr_pc();
        trigger_in[0] = 1'b1; ticks(3);
        trigger_in[0] = 1'b0; ticks(12);
        chk("glitch_count", 32'(pc[0]), 32'd0);
        chk("glitch_level", 32'(level_out[0]), 32'd0);
        clr_pc();
        trigger_in[0] = 1'b1; ticks(4);
        trigger_in[0] = 1'b0; ticks(12);
        chk("min_pulse_count", 32'(pc[0]), 32'd1);

        // ch1 both-edge mode, then disabled mode.
        edge_mode[3:2] = 2'b10;
        clr_pc();
        for (int k = 0; k < 4; k++) begin
            trigger_in[1] = ~trigger_in[1];
            ticks(12);
        end
        chk("both_count", 32'(pc[1]), 32'd4);
        edge_mode[3:2] = 2'b11;
        clr_pc();
        for (int k = 0; k < 4; k++) begin
            trigger_in[1] = ~trigger_in[1];
            ticks(12);
            chk("disabled_level", 32'(level_out[1]), 32'(k % 2 == 0 ? 0 : 1));
        end
        chk("disabled_count", 32'(pc[1]), 32'd0);

        // Auto-repeat: rise accepted at k+5, release sampled at k+23 -> fall accepted at rise+18+5.
        clr_pc();
        trigger_in[0] = 1'b1; ticks(23);
        trigger_in[0] = 1'b0; ticks(15);
        chk("repeat_count", 32'(pc[0]), 32'd6);

        // Reset mid-debounce.
        trigger_in[0] = 1'b1; ticks(4);
        reset = 1'b1; tick();
        chk("rst_dbnc_level", 32'(level_out), 32'h3);
        chk("rst_dbnc_pulse", 32'(pulse_out), 32'h0);
        reset = 1'b0;
        ticks(3);
        trigger_in[0] = 1'b0; ticks(12);
        trigger_in[0] = 1'b1; ticks(15);
        reset = 1'b1; tick();
        chk("rst_rpt_pulse", 32'(pulse_out), 32'h0);
        chk("rst_rpt_level", 32'(level_out), 32'h3);
        edge_mode = 4'b1101;
        trigger_in = 2'b10;
        reset = 1'b0;
        clr_pc();
        ticks(12);
        chk("post_reset_fall", 32'(pc[0]), 32'd1);

        // Randomized stimulus with occasional mode changes and resets.
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < CH; c++) begin
                if (hold[c] == 0) begin
                    trigger_in[c] = 1'($urandom_range(0, 1));
                    hold[c] = int'($urandom_range(1, 14));
                end
                hold[c]--;
            end
            if ($urandom_range(0, 39) == 0) edge_mode = 4'($urandom());
            reset = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
